// File: rtl/fp_wb_scoreboard_pkg.sv
// Shared parameters and payload types for the FP writeback scoreboard.
package fp_sb_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned MAX_LAT  = 8;
    localparam int unsigned LAT_W    = $clog2(MAX_LAT + 1);
    localparam int unsigned IDX_W    = $clog2(MAX_LAT);

    // One reservation slot: a pending writeback to rd.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } wb_slot_t;

    // Latencies outside 1..MAX_LAT never reserve the writeback port.
    function automatic logic lat_legal(input logic [LAT_W-1:0] lat);
        return (lat != '0) && (lat <= LAT_W'(MAX_LAT));
    endfunction

endpackage

// File: rtl/fp_wb_scoreboard_if.sv
// ID-stage issue request, hazard stall and writeback tag between ID and the scoreboard.
interface fp_wb_scoreboard_if;
    import fp_sb_pkg::*;

    logic                issue_valid;
    logic                issue_writes_rf;
    logic [REG_W-1:0]    issue_rd;
    logic [LAT_W-1:0]    issue_latency;
    logic [2:0]          id_rs_use;
    logic [REG_W-1:0]    id_rs1;
    logic [REG_W-1:0]    id_rs2;
    logic [REG_W-1:0]    id_rs3;
    logic                flush;
    logic                stall_id;
    logic                wb_valid;
    logic [REG_W-1:0]    wb_rd;
    logic [NUM_REGS-1:0] busy_vec;

    modport master (
        output issue_valid, issue_writes_rf, issue_rd, issue_latency,
        output id_rs_use, id_rs1, id_rs2, id_rs3, flush,
        input  stall_id, wb_valid, wb_rd, busy_vec
    );

    modport slave (
        input  issue_valid, issue_writes_rf, issue_rd, issue_latency,
        input  id_rs_use, id_rs1, id_rs2, id_rs3, flush,
        output stall_id, wb_valid, wb_rd, busy_vec
    );

endinterface

// File: rtl/fp_wb_reservation_pipe.sv
// Writeback reservation shift register: slot k writes back k cycles from now.
module fp_wb_reservation_pipe
    import fp_sb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_en,
    input  logic [IDX_W-1:0]   load_idx,
    input  logic [REG_W-1:0]   load_rd,
    output wb_slot_t           head,
    output logic [MAX_LAT-1:0] occ
);

    wb_slot_t slots_q [MAX_LAT];
    wb_slot_t slots_d [MAX_LAT];

    // Shift toward slot 0, empty the top, then drop the new reservation in place.
    always_comb begin
        for (int k = 0; k < int'(MAX_LAT) - 1; k++) begin
            slots_d[k] = slots_q[k+1];
        end
        slots_d[MAX_LAT-1] = '0;
        for (int k = 0; k < int'(MAX_LAT); k++) begin
            if (load_en && (load_idx == IDX_W'(k))) begin
                slots_d[k] = '{valid: 1'b1, rd: load_rd};
            end
        end
    end

    // Slot registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(MAX_LAT); k++) begin
                slots_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(MAX_LAT); k++) begin
                slots_q[k] <= slots_d[k];
            end
        end
    end

    // Head slot is this cycle's writeback; occupancy feeds the port-conflict check.
    always_comb begin
        head = slots_q[0];
        for (int k = 0; k < int'(MAX_LAT); k++) begin
            occ[k] = slots_q[k].valid;
        end
    end

endmodule

// File: rtl/fp_wb_scoreboard.sv
// FP writeback scoreboard: tracks in-flight results and stalls ID on RAW, WAW and WB-port hazards.
module fp_wb_scoreboard
    import fp_sb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    fp_wb_scoreboard_if.slave  sb
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [REG_W-1:0]    rs [3];
    logic                writes_eff;
    logic                raw_hit;
    logic                waw_hit;
    logic                struct_hit;
    logic                stall_c;
    logic                accept;
    wb_slot_t            head;
    logic [MAX_LAT-1:0]  occ;

    // Hazard detection and the accept decision for the instruction in ID.
    always_comb begin
        rs[0]      = sb.id_rs1;
        rs[1]      = sb.id_rs2;
        rs[2]      = sb.id_rs3;
        writes_eff = sb.issue_writes_rf & lat_legal(sb.issue_latency);
        raw_hit    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sb.id_rs_use[i] && busy_q[rs[i]] && !(head.valid && (head.rd == rs[i]))) begin
                raw_hit = 1'b1;
            end
        end
        waw_hit    = writes_eff & busy_q[sb.issue_rd];
        struct_hit = 1'b0;
        if (writes_eff && (sb.issue_latency < LAT_W'(MAX_LAT))) begin
            struct_hit = occ[IDX_W'(sb.issue_latency)];
        end
        stall_c = sb.issue_valid & ~sb.flush & (raw_hit | waw_hit | struct_hit);
        accept  = sb.issue_valid & writes_eff & ~stall_c & ~sb.flush;
    end

    // Busy bits: clear on the retiring writeback, set on accept (never the same reg).
    always_comb begin
        busy_d = busy_q;
        if (head.valid) begin
            busy_d[head.rd] = 1'b0;
        end
        if (accept) begin
            busy_d[sb.issue_rd] = 1'b1;
        end
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    fp_wb_reservation_pipe u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (accept),
        .load_idx (IDX_W'(sb.issue_latency - LAT_W'(1))),
        .load_rd  (sb.issue_rd),
        .head     (head),
        .occ      (occ)
    );

    assign sb.stall_id = stall_c;
    assign sb.wb_valid = head.valid;
    assign sb.wb_rd    = head.rd;
    assign sb.busy_vec = busy_q;

endmodule

// File: tb/tb_fp_wb_scoreboard.sv
// Self-checking bench for fp_wb_scoreboard: directed table, corner sequences, random vs model.
module tb_fp_wb_scoreboard;
    import fp_sb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_wb_scoreboard_if sb_if();

    fp_wb_scoreboard dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    typedef struct {
        logic       v;
        logic       w;
        int         rd;
        int         lat;
        logic [2:0] rs_use;
        int         rs1;
        int         rs2;
        int         rs3;
        logic       fl;
    } drv_t;

    typedef struct {
        drv_t        d;
        logic        exp_stall;
        logic        exp_wbv;
        int          exp_wbrd;
        logic [31:0] exp_busy;
    } vec_t;

    // Reference model: list of in-flight ops with their absolute writeback cycle.
    typedef struct {
        int rd;
        int wb;
    } op_t;

    op_t         q[$];
    int          cyc;
    int          n_pass;
    int          n_chk;
    logic        obs_stall;
    logic        obs_wbv;
    logic [31:0] obs_wbrd;
    logic [31:0] obs_busy;
    vec_t        tbl [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (model cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic drv_t mk(input logic v, input logic w, input int rd, input int lat,
                                input logic [2:0] u, input int r1, input int r2, input int r3,
                                input logic fl);
        drv_t d;
        d.v = v; d.w = w; d.rd = rd; d.lat = lat; d.rs_use = u;
        d.rs1 = r1; d.rs2 = r2; d.rs3 = r3; d.fl = fl;
        return d;
    endfunction

    function automatic drv_t idle();
        return mk(1'b0, 1'b0, 0, 1, 3'b000, 0, 0, 0, 1'b0);
    endfunction

    function automatic drv_t iss(input int rd, input int lat);
        return mk(1'b1, 1'b1, rd, lat, 3'b000, 0, 0, 0, 1'b0);
    endfunction

    function automatic vec_t tv(input drv_t d, input logic s, input logic wv, input int wr,
                                input logic [31:0] b);
        vec_t t;
        t.d = d; t.exp_stall = s; t.exp_wbv = wv; t.exp_wbrd = wr; t.exp_busy = b;
        return t;
    endfunction

    function automatic logic in_flight(input int rd);
        foreach (q[i]) if (q[i].rd == rd) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic port_taken(input int c);
        foreach (q[i]) if (q[i].wb == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int wb_rd_at(input int c);
        foreach (q[i]) if (q[i].wb == c) return q[i].rd;
        return -1;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        foreach (q[i]) b = b | (32'(1) << q[i].rd);
        return b;
    endfunction

    // Drive one cycle, compare against the model at the falling edge, advance the model.
    task automatic step(input drv_t d);
        int   wr;
        int   rsv [3];
        logic ev, raw, waw, st, stall, acc;
        sb_if.issue_valid     = d.v;
        sb_if.issue_writes_rf = d.w;
        sb_if.issue_rd        = REG_W'(d.rd);
        sb_if.issue_latency   = LAT_W'(d.lat);
        sb_if.id_rs_use       = d.rs_use;
        sb_if.id_rs1          = REG_W'(d.rs1);
        sb_if.id_rs2          = REG_W'(d.rs2);
        sb_if.id_rs3          = REG_W'(d.rs3);
        sb_if.flush           = d.fl;
        @(negedge clk);
        obs_stall = sb_if.stall_id;
        obs_wbv   = sb_if.wb_valid;
        obs_wbrd  = 32'(sb_if.wb_rd);
        obs_busy  = sb_if.busy_vec;
        wr  = wb_rd_at(cyc);
        ev  = (wr >= 0);
        rsv[0] = d.rs1; rsv[1] = d.rs2; rsv[2] = d.rs3;
        raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (d.rs_use[i] && in_flight(rsv[i]) && !(ev && wr == rsv[i])) raw = 1'b1;
        end
        waw   = d.w && in_flight(d.rd);
        st    = d.w && port_taken(cyc + d.lat);
        stall = d.v && !d.fl && (raw || waw || st);
        acc   = d.v && d.w && !d.fl && !stall;
        check("m_stall", 32'(obs_stall), 32'(stall));
        check("m_wb_valid", 32'(obs_wbv), 32'(ev));
        if (ev) check("m_wb_rd", obs_wbrd, 32'(wr));
        check("m_busy_vec", obs_busy, model_busy());
        @(posedge clk);
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].wb == cyc) q.delete(i);
        if (acc) q.push_back('{rd: d.rd, wb: cyc + d.lat});
        cyc++;
        #1;
    endtask

    // Out-of-range latency on a writing issue is a stimulus error.
    always @(posedge clk) begin
        if (rst_n && sb_if.issue_valid && sb_if.issue_writes_rf) begin
            assert (sb_if.issue_latency != '0 && sb_if.issue_latency <= LAT_W'(MAX_LAT))
                else $error("illegal issue_latency %0d", sb_if.issue_latency);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        drv_t ru;
        drv_t d;
        n_pass = 0;
        n_chk  = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        sb_if.issue_valid = 1'b0; sb_if.issue_writes_rf = 1'b0; sb_if.issue_rd = '0;
        sb_if.issue_latency = LAT_W'(1); sb_if.id_rs_use = '0; sb_if.id_rs1 = '0;
        sb_if.id_rs2 = '0; sb_if.id_rs3 = '0; sb_if.flush = 1'b0;

        // Reset state
        #3;
        check("rst_wb_valid", 32'(sb_if.wb_valid), 32'd0);
        check("rst_wb_rd", 32'(sb_if.wb_rd), 32'd0);
        check("rst_busy_vec", sb_if.busy_vec, 32'd0);
        check("rst_stall", 32'(sb_if.stall_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: latency, structural, RAW+bypass, flush
        ru = mk(1'b1, 1'b0, 0, 1, 3'b001, 7, 0, 0, 1'b0);
        tbl[0]  = tv(iss(5, 3), 0, 0, 0, 32'h0);
        tbl[1]  = tv(idle(),    0, 0, 0, 32'h20);
        tbl[2]  = tv(idle(),    0, 0, 0, 32'h20);
        tbl[3]  = tv(idle(),    0, 1, 5, 32'h20);
        tbl[4]  = tv(idle(),    0, 0, 0, 32'h0);
        tbl[5]  = tv(iss(2, 4), 0, 0, 0, 32'h0);
        tbl[6]  = tv(iss(3, 3), 1, 0, 0, 32'h4);
        tbl[7]  = tv(idle(),    0, 0, 0, 32'h4);
        tbl[8]  = tv(idle(),    0, 0, 0, 32'h4);
        tbl[9]  = tv(idle(),    0, 1, 2, 32'h4);
        tbl[10] = tv(iss(2, 4), 0, 0, 0, 32'h0);
        tbl[11] = tv(iss(3, 2), 0, 0, 0, 32'h4);
        tbl[12] = tv(idle(),    0, 0, 0, 32'hC);
        tbl[13] = tv(idle(),    0, 1, 3, 32'hC);
        tbl[14] = tv(idle(),    0, 1, 2, 32'h4);
        tbl[15] = tv(idle(),    0, 0, 0, 32'h0);
        tbl[16] = tv(iss(7, 4), 0, 0, 0, 32'h0);
        tbl[17] = tv(ru,        1, 0, 0, 32'h80);
        tbl[18] = tv(ru,        1, 0, 0, 32'h80);
        tbl[19] = tv(ru,        1, 0, 0, 32'h80);
        tbl[20] = tv(ru,        0, 1, 7, 32'h80);
        tbl[21] = tv(idle(),    0, 0, 0, 32'h0);
        tbl[22] = tv(mk(1'b1, 1'b1, 4, 1, 3'b000, 0, 0, 0, 1'b1), 0, 0, 0, 32'h0);
        tbl[23] = tv(idle(),    0, 0, 0, 32'h0);
        for (int i = 0; i < 24; i++) begin
            step(tbl[i].d);
            check($sformatf("tbl%0d_stall", i), 32'(obs_stall), 32'(tbl[i].exp_stall));
            check($sformatf("tbl%0d_wb_valid", i), 32'(obs_wbv), 32'(tbl[i].exp_wbv));
            if (tbl[i].exp_wbv) check($sformatf("tbl%0d_wb_rd", i), obs_wbrd, 32'(tbl[i].exp_wbrd));
            check($sformatf("tbl%0d_busy", i), obs_busy, tbl[i].exp_busy);
        end

        // WAW: rd 9 L6 in flight, then rd 9 L1 waits past the writeback cycle
        step(iss(9, 6));
        for (int k = 1; k <= 7; k++) begin
            step(iss(9, 1));
            check($sformatf("waw_stall_%0d", k), 32'(obs_stall), (k < 7) ? 32'd1 : 32'd0);
            if (k == 6) begin
                check("waw_first_wb_valid", 32'(obs_wbv), 32'd1);
                check("waw_first_wb_rd", obs_wbrd, 32'd9);
            end
        end
        step(idle());
        check("waw_second_wb_valid", 32'(obs_wbv), 32'd1);
        check("waw_second_wb_rd", obs_wbrd, 32'd9);
        step(idle());

        // Reset with three ops in flight
        step(iss(1, 8));
        step(iss(2, 8));
        step(iss(3, 8));
        step(idle());
        check("pre_rst_busy", obs_busy, 32'hE);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wb_valid", 32'(sb_if.wb_valid), 32'd0);
        check("mid_rst_busy", sb_if.busy_vec, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < 12; k++) begin
            step(idle());
            check($sformatf("post_rst_wb_%0d", k), 32'(obs_wbv), 32'd0);
        end

        // Constrained-random issue/flush against the model
        for (int n = 0; n < 10000; n++) begin
            d.v      = ($urandom_range(0, 9) < 7);
            d.w      = ($urandom_range(0, 9) < 8);
            d.rd     = int'($urandom_range(0, 7));
            d.lat    = int'($urandom_range(1, MAX_LAT));
            d.rs_use = 3'($urandom_range(0, 7));
            d.rs1    = int'($urandom_range(0, 7));
            d.rs2    = int'($urandom_range(0, 7));
            d.rs3    = int'($urandom_range(0, 7));
            d.fl     = ($urandom_range(0, 9) == 0);
            step(d);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
